// File: rtl/seq_add_sub.sv
// -----------------------------------------------------------------------------
// seq_add_sub
//   Multi-cycle WIDTH-bit adder/subtractor. Processes one CHUNK-bit slice per
//   clock, LSB slice first, chaining the carry between slices. Subtraction is
//   done as A + ~B + 1, so in sub mode the carry-out means "no borrow".
//   A start/busy/done handshake frames each operation. Result and flags are
//   registered and change only when the last slice completes (or on reset).
//
// Parameters
//   WIDTH : operand/result width, positive multiple of CHUNK
//   CHUNK : slice width per cycle; N = WIDTH/CHUNK cycles per operation
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   operation request, sampled only when not busy
//   sub      in   0 = A+B, 1 = A-B (sampled with start)
//   a, b     in   operands (sampled with start)
//   busy     out  high while slices are being processed
//   done     out  one-cycle pulse when result/flags update
//   result   out  last completed result
//   carry    out  final carry-out (sub: 1 = A >= B unsigned)
//   overflow out  two's-complement overflow of the last result
// -----------------------------------------------------------------------------
module seq_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;     // already inverted in sub mode
    logic             r_c;        // carry into the current slice
    logic [CW-1:0]    r_cnt;      // index of the slice being processed
    logic [WIDTH-1:0] r_sum;      // partial sum, filled slice by slice
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;

    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK:0]   w_slice_sum;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;
    logic             w_ovf;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_a_slice   = r_op_a[r_cnt*CHUNK +: CHUNK];
        w_b_slice   = r_op_b[r_cnt*CHUNK +: CHUNK];
        w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_c};
        w_sum_next  = r_sum;
        w_sum_next[r_cnt*CHUNK +: CHUNK] = w_slice_sum[CHUNK-1:0];
    end

    assign w_last = (r_cnt == CW'(N - 1));

    // Operands with equal sign producing a sum of the other sign. Using the
    // inverted B makes this one rule cover both add and subtract.
    assign w_ovf = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                   (w_sum_next[WIDTH-1] != r_op_a[WIDTH-1]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the operand/sum registers are reset as well so a
    // mid-operation reset leaves no stale data visible anywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_c        <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_c     <= sub;            // the +1 of two's complement
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum <= w_sum_next;
                    r_c   <= w_slice_sum[CHUNK];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result   <= w_sum_next;
                        r_carry    <= w_slice_sum[CHUNK];
                        r_overflow <= w_ovf;
                        r_state    <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_seq_add_sub.sv
// -----------------------------------------------------------------------------
// tb_seq_add_sub
//   Scoreboard bench for seq_add_sub. Expected results come from an unsigned /
//   signed integer model and are queued when an operation is launched; a
//   monitor pops and compares them on each done pulse, together with latency
//   and busy length. A second instance (WIDTH=8, CHUNK=8) covers N=1.
// -----------------------------------------------------------------------------
module tb_seq_add_sub;

    localparam int W = 32;
    localparam int C = 8;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, sub;
    logic [W-1:0] a, b;
    logic         busy, done, carry, overflow;
    logic [W-1:0] result;

    logic       s_start, s_sub;
    logic [7:0] s_a, s_b;
    logic       s_busy, s_done, s_carry, s_overflow;
    logic [7:0] s_result;

    seq_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry),
        .overflow(overflow)
    );

    seq_add_sub #(.WIDTH(8), .CHUNK(8)) dut_n1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
        .busy(s_busy), .done(s_done), .result(s_result), .carry(s_carry),
        .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         ov;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   busy_len = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model built from plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int dcyc);
        exp_t   e;
        longint ux, uy, sx, sy, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            e.res = W'(ux - uy);
            e.cy  = (ux >= uy);
            sr    = sx - sy;
        end else begin
            e.res = W'(ux + uy);
            e.cy  = ((ux + uy) >= (longint'(1) << W));
            sr    = sx + sy;
        end
        e.ov       = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        e.done_cyc = dcyc;
        return e;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                done_cnt++;
                check("busy_with_done", busy, 0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result",   result,   e.res);
                    check("carry",    carry,    e.cy);
                    check("overflow", overflow, e.ov);
                    check("latency",  cyc,      e.done_cyc);
                    check("busy_len", busy_len, N);
                end
                busy_len = 0;
            end
        end
    end

    // Drive start at a falling edge; the next rising edge (cyc+1) samples it.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        start = 1'b1; a = x; b = y; sub = s;
        sb.push_back(model(x, y, s, cyc + 1 + N));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        launch(x, y, s);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        int budget;
        budget = 30;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int       d0;
        logic [W-1:0] first_res;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
        #12;
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_result",   result,   0);
        check("rst_carry",    carry,    0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: no done pulse.
        repeat (3) @(negedge clk);
        check("idle_no_done", done_cnt, 0);

        // Directed corner cases plus a few random operations.
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0); wait_empty();
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0); wait_empty();
        run_op(32'h8000_0000, 32'h1, 1'b1); wait_empty();
        run_op(32'd2,  32'd3,  1'b1);       wait_empty();
        run_op(32'd15, 32'd11, 1'b1);       wait_empty();
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
            wait_empty();
        end

        // start during RUN is ignored; operands change freely meanwhile.
        run_op(32'h1234_5678, 32'h0101_0101, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();

        // Back-to-back: start held during the DONE cycle.
        run_op(32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
        first_res = 32'hA5A5_5A5A;
        d0 = done_cnt;
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        launch(32'h0000_0010, 32'h0000_0020, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check("hold_busy", busy, 1);
            check("hold_result", result, first_res);
            @(negedge clk);
        end
        wait_empty();
        check("b2b_done_count", done_cnt - d0, 2);

        // Asynchronous reset mid-clock with non-zero outputs.
        #3 rst_n = 1'b0;
        #1;
        check("arst_result",   result,   0);
        check("arst_carry",    carry,    0);
        check("arst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Give outputs a non-zero value, then abort the next op at RUN cycle 2.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_empty();
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0);
        d0 = done_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",     busy,     0);
        check("abort_done",     done,     0);
        check("abort_result",   result,   0);
        check("abort_carry",    carry,    0);
        check("abort_overflow", overflow, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        // N = 1 instance: 111 + 41.
        @(negedge clk);
        s_start = 1'b1; s_a = 8'd111; s_b = 8'd41; s_sub = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        check("n1_busy",   s_busy, 1);
        check("n1_early",  s_done, 0);
        @(negedge clk);
        check("n1_done",     s_done,     1);
        check("n1_result",   s_result,   8'd152);
        check("n1_carry",    s_carry,    0);
        check("n1_overflow", s_overflow, 1);
        @(negedge clk);
        check("n1_pulse", s_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
